// File: rtl/bram_xfer_ctrl_pkg.sv
// Shared encodings for the BRAM transfer sequencer: command modes, FSM states,
// PS register bit-field positions and status-word packing.
package bram_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_COPY    = 2'd0,
    MODE_REVERSE = 2'd1,
    MODE_FILL    = 2'd2,
    MODE_ILLEGAL = 2'd3
  } xfer_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } xfer_state_e;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_MODE_LSB  = 1;
  localparam int unsigned CTRL_ABORT_BIT = 31;
  localparam int unsigned PARAM_SRC_LSB  = 0;
  localparam int unsigned PARAM_DST_LSB  = 16;
  localparam int unsigned PARAM_BASE_W   = 11;
  localparam int unsigned LENGTH_W       = 12;
  localparam int unsigned STAT_DONE_BIT  = 0;
  localparam int unsigned STAT_ERROR_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT  = 2;
  localparam int unsigned STAT_COUNT_LSB = 16;
  localparam int unsigned STAT_COUNT_W   = 12;

  function automatic logic [31:0] pack_status(input logic done, input logic error,
                                              input logic busy,
                                              input logic [STAT_COUNT_W-1:0] count);
    logic [31:0] s;
    s = '0;
    s[STAT_DONE_BIT]  = done;
    s[STAT_ERROR_BIT] = error;
    s[STAT_BUSY_BIT]  = busy;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/bram_xfer_ctrl_if.sv
// PS register words and both BRAM datapath ports of the transfer sequencer.
interface bram_xfer_ctrl_if #(
  parameter int unsigned ADDRWIDTH = 13
);
  logic [31:0]          ps_control;
  logic [31:0]          ps_param;
  logic [31:0]          ps_length;
  logic [31:0]          ps_fill_value;
  logic [31:0]          pl_status;
  logic [ADDRWIDTH-1:0] src_addr;
  logic [31:0]          src_rddata;
  logic [ADDRWIDTH-1:0] dst_addr;
  logic [31:0]          dst_wrdata;
  logic [3:0]           dst_we;

  modport master (
    input  ps_control, ps_param, ps_length, ps_fill_value, src_rddata,
    output pl_status, src_addr, dst_addr, dst_wrdata, dst_we
  );

  modport slave (
    output ps_control, ps_param, ps_length, ps_fill_value, src_rddata,
    input  pl_status, src_addr, dst_addr, dst_wrdata, dst_we
  );
endinterface

// File: rtl/bram_xfer_ctrl_xfer_issue_pipe.sv
// Issue pipeline matching the source BRAM read latency: carries {valid, dst index}
// so each write lines up with the read data of its source word.
module xfer_issue_pipe #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned IDXW       = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [IDXW-1:0] in_idx,
  output logic            out_valid,
  output logic [IDXW-1:0] out_idx,
  output logic            busy
);

  logic [RD_LATENCY-1:0] valid_q, valid_d;
  logic [IDXW-1:0]       idx_q [RD_LATENCY];
  logic [IDXW-1:0]       idx_d [RD_LATENCY];

  always_comb begin
    valid_d    = '0;
    idx_d      = idx_q;
    valid_d[0] = in_valid & ~flush;
    idx_d[0]   = in_idx;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1] & ~flush;
      idx_d[i]   = idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    idx_q <= idx_d;
  end

  always_comb begin
    out_valid = valid_q[RD_LATENCY-1];
    out_idx   = idx_q[RD_LATENCY-1];
    busy      = |valid_q;
  end

endmodule

// File: rtl/bram_xfer_ctrl.sv
// Transfer sequencer: runs one copy / reverse-copy / fill command at a time from
// BRAM 0 into BRAM 1 and reports done/error/busy/count on pl_status.
module bram_xfer_ctrl
  import bram_xfer_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  bram_xfer_ctrl_if.master bus
);

  localparam int unsigned IDXW      = $clog2(DEPTH);
  localparam int unsigned ADDRWIDTH = $clog2(DEPTH) + 2;

  xfer_state_e           state_q, state_d;
  xfer_mode_e            mode_q, mode_d;
  logic [31:0]           fill_q, fill_d;
  logic [LENGTH_W-1:0]   len_q, len_d, idx_q, idx_d, count_q, count_d;
  logic [IDXW-1:0]       src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic                  error_q, error_d;
  logic [ADDRWIDTH-1:0]  src_addr_q, src_addr_d, dst_addr_q, dst_addr_d;
  logic                  dst_we_q, dst_we_d;

  logic                  start, abort, cmd_legal;
  xfer_mode_e            cmd_mode;
  logic [LENGTH_W-1:0]   cmd_len;
  logic [IDXW-1:0]       cmd_src_w, cmd_first_dst;

  logic                  push_valid, flush;
  logic [IDXW-1:0]       push_idx;
  logic                  pipe_out_valid, pipe_busy;
  logic [IDXW-1:0]       pipe_out_idx;

  function automatic logic [IDXW-1:0] inc_wrap(input logic [IDXW-1:0] x);
    return (32'(x) == DEPTH - 1) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [IDXW-1:0] dec_wrap(input logic [IDXW-1:0] x);
    return (x == '0) ? IDXW'(DEPTH - 1) : x - 1'b1;
  endfunction

  always_comb begin
    start     = bus.ps_control[CTRL_START_BIT];
    abort     = bus.ps_control[CTRL_ABORT_BIT];
    cmd_mode  = xfer_mode_e'(bus.ps_control[CTRL_MODE_LSB +: 2]);
    cmd_len   = bus.ps_length[LENGTH_W-1:0];
    cmd_legal = (cmd_mode != MODE_ILLEGAL) && (cmd_len != '0) && (32'(cmd_len) <= DEPTH);
    cmd_src_w = IDXW'(32'(bus.ps_param[PARAM_SRC_LSB +: PARAM_BASE_W]) % DEPTH);
    // Reverse starts at the far end of the destination range and walks down.
    if (cmd_mode == MODE_REVERSE) begin
      cmd_first_dst = IDXW'((32'(bus.ps_param[PARAM_DST_LSB +: PARAM_BASE_W]) +
                             32'(cmd_len) + DEPTH - 1) % DEPTH);
    end else begin
      cmd_first_dst = IDXW'(32'(bus.ps_param[PARAM_DST_LSB +: PARAM_BASE_W]) % DEPTH);
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    fill_d     = fill_q;
    len_d      = len_q;
    idx_d      = idx_q;
    count_d    = count_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    error_d    = error_q;
    src_addr_d = src_addr_q;
    push_valid = 1'b0;
    push_idx   = dst_ptr_q;
    flush      = 1'b0;

    if (dst_we_q && (32'(count_q) < DEPTH)) begin
      count_d = count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = cmd_mode;
          fill_d  = bus.ps_fill_value;
          len_d   = cmd_len;
          count_d = '0;
          error_d = 1'b0;
          if (cmd_legal) begin
            // Index 0 is issued while accepting so it reaches src_addr in the first RUN cycle.
            push_valid = 1'b1;
            push_idx   = cmd_first_dst;
            src_addr_d = {cmd_src_w, 2'b00};
            src_ptr_d  = inc_wrap(cmd_src_w);
            dst_ptr_d  = (cmd_mode == MODE_REVERSE) ? dec_wrap(cmd_first_dst)
                                                    : inc_wrap(cmd_first_dst);
            idx_d      = LENGTH_W'(1);
            state_d    = ST_RUN;
          end else begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          flush   = 1'b1;
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          if (idx_q < len_q) begin
            push_valid = 1'b1;
            src_addr_d = {src_ptr_q, 2'b00};
            src_ptr_d  = inc_wrap(src_ptr_q);
            dst_ptr_d  = (mode_q == MODE_REVERSE) ? dec_wrap(dst_ptr_q) : inc_wrap(dst_ptr_q);
            idx_d      = idx_q + 1'b1;
          end
          if ((idx_q + 1'b1) >= len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          error_d = 1'b1;
          state_d = ST_DONE;
        end else if (!pipe_busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!start) begin
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dst_we_d   = pipe_out_valid && !flush;
    dst_addr_d = dst_we_d ? {pipe_out_idx, 2'b00} : dst_addr_q;
  end

  xfer_issue_pipe #(
    .RD_LATENCY(RD_LATENCY),
    .IDXW      (IDXW)
  ) u_issue_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (push_valid),
    .in_idx   (push_idx),
    .out_valid(pipe_out_valid),
    .out_idx  (pipe_out_idx),
    .busy     (pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_COPY;
      fill_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      error_q    <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      fill_q     <= fill_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      error_q    <= error_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_we_q   <= dst_we_d;
    end
  end

  always_comb begin
    bus.pl_status  = pack_status(state_q == ST_DONE, error_q,
                                 (state_q == ST_RUN) || (state_q == ST_DRAIN), count_q);
    bus.src_addr   = src_addr_q;
    bus.dst_addr   = dst_addr_q;
    bus.dst_we     = {4{dst_we_q}};
    bus.dst_wrdata = (mode_q == MODE_FILL) ? fill_q : bus.src_rddata;
  end

endmodule

// File: tb/tb_bram_xfer_ctrl.sv
// Bench for bram_xfer_ctrl: two instances (read latency 1 and 2) share the PS
// inputs; results are checked against a word-level model of each command.
module tb_bram_xfer_ctrl;
  import bram_xfer_ctrl_pkg::*;

  localparam int unsigned DEPTH = 2048;
  localparam int unsigned AW    = 13;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] a;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear_mem = 1'b1;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ps_control = '0, ps_param = '0, ps_length = '0, ps_fill = '0;

  bram_xfer_ctrl_if #(.ADDRWIDTH(AW)) bus_a ();
  bram_xfer_ctrl_if #(.ADDRWIDTH(AW)) bus_b ();

  bram_xfer_ctrl #(.DEPTH(DEPTH), .RD_LATENCY(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  bram_xfer_ctrl #(.DEPTH(DEPTH), .RD_LATENCY(2)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  assign bus_a.ps_control = ps_control;   assign bus_b.ps_control = ps_control;
  assign bus_a.ps_param = ps_param;       assign bus_b.ps_param = ps_param;
  assign bus_a.ps_length = ps_length;     assign bus_b.ps_length = ps_length;
  assign bus_a.ps_fill_value = ps_fill;   assign bus_b.ps_fill_value = ps_fill;

  // Source BRAM with registered output: one register for latency 1, two for latency 2.
  logic [31:0] mem0 [DEPTH];
  logic [31:0] rd_a, rd_b1, rd_b2;
  always @(posedge clk) begin
    rd_a  <= mem0[bus_a.src_addr[AW-1:2]];
    rd_b1 <= mem0[bus_b.src_addr[AW-1:2]];
    rd_b2 <= rd_b1;
  end
  assign bus_a.src_rddata = rd_a;
  assign bus_b.src_rddata = rd_b2;

  logic [31:0] mem1a [DEPTH];
  logic [31:0] mem1b [DEPTH];
  wr_t log_a[$];
  wr_t log_b[$];
  int unsigned bad_we = 0;

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem1a[w] <= 32'h5A5A_0000 | 32'(w);
        mem1b[w] <= 32'h5A5A_0000 | 32'(w);
      end
    end else begin
      if (bus_a.dst_we == 4'hf) begin
        mem1a[bus_a.dst_addr[AW-1:2]] <= bus_a.dst_wrdata;
        log_a.push_back('{c: cyc, a: 32'(bus_a.dst_addr)});
      end
      if (bus_b.dst_we == 4'hf) begin
        mem1b[bus_b.dst_addr[AW-1:2]] <= bus_b.dst_wrdata;
        log_b.push_back('{c: cyc, a: 32'(bus_b.dst_addr)});
      end
    end
    if (reset_n && ((bus_a.dst_we !== 4'h0 && bus_a.dst_we !== 4'hf) ||
                    (bus_b.dst_we !== 4'h0 && bus_b.dst_we !== 4'hf))) bad_we <= bad_we + 1;
  end

  logic [31:0] exp1 [2][DEPTH];
  int unsigned total = 0, passed = 0;
  int unsigned lat [2] = '{1, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stat(input int d);
    return (d == 0) ? bus_a.pl_status : bus_b.pl_status;
  endfunction

  function automatic int unsigned log_size(input int d);
    return (d == 0) ? log_a.size() : log_b.size();
  endfunction

  function automatic wr_t log_at(input int d, input int unsigned k);
    return (d == 0) ? log_a[k] : log_b[k];
  endfunction

  function automatic int unsigned dst_word(input int unsigned mode, dst, len, i);
    return (mode == 1) ? (dst + len - 1 - i) % DEPTH : (dst + i) % DEPTH;
  endfunction

  function automatic int unsigned mem_diffs(input int d);
    int unsigned n = 0;
    for (int w = 0; w < DEPTH; w++) begin
      if (((d == 0) ? mem1a[w] : mem1b[w]) !== exp1[d][w]) n++;
    end
    return n;
  endfunction

  task automatic apply_model(input int d, input int unsigned mode, src, dst, len,
                             input logic [31:0] fv, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      exp1[d][dst_word(mode, dst, len, i)] = (mode == 2) ? fv : mem0[(src + i) % DEPTH];
    end
  endtask

  task automatic run_cmd(input string name, input int unsigned mode, src, dst, len,
                         input logic [31:0] fv, input int unsigned abort_at);
    int unsigned lb [2], done_cyc [2], c0, k, n, exp_done;
    logic [31:0] st_done [2];
    logic [31:0] s;
    logic legal;
    wr_t w;
    string sfx;
    legal = (mode != 3) && (len != 0) && (len <= DEPTH);
    for (int d = 0; d < 2; d++) begin
      lb[d] = log_size(d);
      done_cyc[d] = 0;
      st_done[d] = '0;
    end
    ps_param   = ((dst & 32'h7ff) << 16) | (src & 32'h7ff);
    ps_length  = len;
    ps_fill    = fv;
    ps_control = 32'(1) | (32'(mode & 3) << 1);
    c0 = cyc;
    k = 0;
    while (k < len + 20 && (done_cyc[0] == 0 || done_cyc[1] == 0)) begin
      tick();
      k++;
      for (int d = 0; d < 2; d++) begin
        s = stat(d);
        if (done_cyc[d] == 0 && s[STAT_DONE_BIT]) begin
          done_cyc[d] = k;
          st_done[d] = s;
        end
        if (k == 1 && legal) chk({name, "_busy_run"}, 32'(s[STAT_BUSY_BIT]), 32'd1);
      end
      if (k == 1) begin
        ps_param   = $urandom;
        ps_length  = $urandom;
        ps_fill    = $urandom;
        ps_control = 32'(1) | (32'($urandom_range(0, 3)) << 1);
      end
      if (abort_at != 0 && k == abort_at) ps_control[CTRL_ABORT_BIT] = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      sfx = (d == 0) ? "_lat1" : "_lat2";
      if (!legal) begin
        n = 0;
        exp_done = 1;
      end else if (abort_at != 0) begin
        n = (abort_at > lat[d]) ? abort_at - lat[d] : 0;
        if (n > len) n = len;
        exp_done = abort_at + 1;
      end else begin
        n = len;
        exp_done = len + lat[d] + 1;
      end
      chk({name, "_done_cycle", sfx}, done_cyc[d], exp_done);
      chk({name, "_error", sfx}, 32'(st_done[d][STAT_ERROR_BIT]), 32'(!legal || abort_at != 0));
      chk({name, "_busy_done", sfx}, 32'(st_done[d][STAT_BUSY_BIT]), 32'd0);
      if (legal) chk({name, "_count", sfx}, 32'(st_done[d][STAT_COUNT_LSB +: STAT_COUNT_W]), n);
      chk({name, "_writes", sfx}, log_size(d) - lb[d], n);
      if (legal && abort_at == 0) begin
        w = log_at(d, lb[d]);
        chk({name, "_first_cyc", sfx}, w.c - c0, 1 + lat[d]);
        chk({name, "_first_addr", sfx}, w.a, 4 * dst_word(mode, dst, len, 0));
        w = log_at(d, lb[d] + n - 1);
        chk({name, "_last_cyc", sfx}, w.c - c0, len + lat[d]);
        chk({name, "_last_addr", sfx}, w.a, 4 * dst_word(mode, dst, len, len - 1));
      end
      apply_model(d, mode, src, dst, len, fv, n);
      chk({name, "_mem_diffs", sfx}, mem_diffs(d), 0);
      lb[d] = log_size(d);
      st_done[d] = 32'(n);
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      s = stat(d);
      chk({name, "_hold_done"}, 32'(s[STAT_DONE_BIT]), 32'd1);
      chk({name, "_no_restart"}, log_size(d) - lb[d], 0);
    end
    ps_control = '0;
    tick();
    for (int d = 0; d < 2; d++) begin
      s = stat(d);
      if (legal) chk({name, "_idle_status"}, s, st_done[d] << STAT_COUNT_LSB);
      else chk({name, "_idle_flags"}, s & 32'h7, 32'd0);
    end
    tick();
  endtask

  initial begin
    int unsigned n, mode, len, ab;
    logic [31:0] s;
    for (int w = 0; w < DEPTH; w++) begin
      mem0[w] = 32'(w);
      exp1[0][w] = 32'h5A5A_0000 | 32'(w);
      exp1[1][w] = 32'h5A5A_0000 | 32'(w);
    end
    repeat (3) tick();
    clear_mem = 1'b0;
    chk("reset_status_a", bus_a.pl_status, 32'd0);
    chk("reset_status_b", bus_b.pl_status, 32'd0);
    chk("reset_src_addr", 32'(bus_a.src_addr) | 32'(bus_b.src_addr), 32'd0);
    chk("reset_dst_addr", 32'(bus_a.dst_addr) | 32'(bus_b.dst_addr), 32'd0);
    chk("reset_dst_we", 32'(bus_a.dst_we) | 32'(bus_b.dst_we), 32'd0);
    reset_n = 1'b1;
    tick();

    run_cmd("copy_full", 0, 0, 0, 2048, 32'h0, 0);
    run_cmd("rev_full", 1, 0, 0, 2048, 32'h0, 0);
    for (int w = 0; w < DEPTH; w++) mem0[w] = $urandom;
    run_cmd("copy_wrap", 0, 2046, 2040, 4, 32'h0, 0);
    run_cmd("fill", 2, 0, 10, 3, 32'hDEAD_BEEF, 0);
    run_cmd("ill_mode", 3, 5, 5, 8, 32'h0, 0);
    run_cmd("ill_len0", 0, 5, 5, 0, 32'h0, 0);
    run_cmd("ill_len2049", 0, 5, 5, 2049, 32'h0, 0);
    run_cmd("abort", 0, 100, 300, 100, 32'h0, 5);

    for (int r = 0; r < 8; r++) begin
      mode = $urandom_range(0, 2);
      len  = $urandom_range(1, 40);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      run_cmd($sformatf("rand%0d", r), mode, $urandom_range(0, DEPTH - 1),
              $urandom_range(0, DEPTH - 1), len, $urandom, ab);
    end

    // Reset in the middle of a 40-word copy started at cycle 0, asserted during cycle 10.
    for (int d = 0; d < 2; d++) exp1[d][0] = exp1[d][0];
    n = log_a.size() + log_b.size();
    ps_param = (32'd500 << 16) | 32'd700;
    ps_length = 40;
    ps_control = 32'd1;
    repeat (10) tick();
    reset_n = 1'b0;
    ps_control = '0;
    tick();
    chk("midreset_status_a", bus_a.pl_status, 32'd0);
    chk("midreset_status_b", bus_b.pl_status, 32'd0);
    chk("midreset_src_addr", 32'(bus_a.src_addr) | 32'(bus_b.src_addr), 32'd0);
    chk("midreset_dst_addr", 32'(bus_a.dst_addr) | 32'(bus_b.dst_addr), 32'd0);
    chk("midreset_dst_we", 32'(bus_a.dst_we) | 32'(bus_b.dst_we), 32'd0);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("midreset_writes", log_a.size() + log_b.size() - n, (10 - 1) + (10 - 2));
    for (int d = 0; d < 2; d++) begin
      s = stat(d);
      chk("midreset_idle", s, 32'd0);
      apply_model(d, 0, 700, 500, 40, 32'h0, 10 - lat[d]);
      chk("midreset_mem_diffs", mem_diffs(d), 0);
    end

    run_cmd("after_reset", 1, 2040, 3, 17, 32'h0, 0);
    chk("dst_we_encoding", bad_we, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
